// File: rtl/long_op_scoreboard_pkg.sv
// long_op_scoreboard_pkg: shared tag/word types, source indices and completion-queue entry
package long_op_scoreboard_pkg;
  typedef logic [4:0] tag_t;
  typedef logic [31:0] word_t;
  localparam int RS1 = 0;
  localparam int RS2 = 1;
  typedef struct packed {
    tag_t  rd;
    word_t value;
  } sb_entry_t;
endpackage

// File: rtl/long_op_scoreboard_if.sv
// long_op_scoreboard_if: issue, completion, writeback and forwarding signals of the scoreboard
interface long_op_scoreboard_if;
  import long_op_scoreboard_pkg::*;
  logic       iss_valid;
  logic       iss_long;
  tag_t       iss_rs1;
  tag_t       iss_rs2;
  logic       iss_use_rs2;
  tag_t       iss_rd;
  logic       stall;
  logic       cmp_valid;
  tag_t       cmp_rd;
  word_t      cmp_value;
  logic       cmp_ready;
  logic       s5_write_rd;
  logic       wb_en;
  tag_t       wb_rd;
  word_t      wb_value;
  logic [1:0] fwd;
  word_t      fwd_rs1;
  word_t      fwd_rs2;
  modport master (
    output iss_valid, iss_long, iss_rs1, iss_rs2, iss_use_rs2, iss_rd,
    output cmp_valid, cmp_rd, cmp_value, s5_write_rd,
    input  stall, cmp_ready, wb_en, wb_rd, wb_value, fwd, fwd_rs1, fwd_rs2
  );
  modport slave (
    input  iss_valid, iss_long, iss_rs1, iss_rs2, iss_use_rs2, iss_rd,
    input  cmp_valid, cmp_rd, cmp_value, s5_write_rd,
    output stall, cmp_ready, wb_en, wb_rd, wb_value, fwd, fwd_rs1, fwd_rs2
  );
endinterface

// File: rtl/long_op_scoreboard_sb_fifo.sv
// sb_fifo: completion queue of long-op results, entry array exposed for the forwarding compare
module sb_fifo
  import long_op_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output sb_entry_t        head,
  output sb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  sb_entry_t     mem [DEPTH];
  logic          do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  assign entries = mem;
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // an entry is live when its distance from the read pointer is below the occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign valid[i] = {1'b0, AW'(i) - rd_ptr} < count;
  end
endmodule

// File: rtl/long_op_scoreboard.sv
// long_op_scoreboard: pending-register tracking, hazard stall and queued writeback of long-op results
// SB_FWD_EN: when defined, queued results are forwarded to S3 sources instead of stalling.
module long_op_scoreboard
  import long_op_scoreboard_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic                 clock,
  input logic                 reset,
  long_op_scoreboard_if.slave sb
);
`ifdef SB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [31:0]           pending;
  logic [OW-1:0]         outstanding;
  logic                  fifo_full, fifo_empty, pop, stall, do_issue;
  logic                  raw1, raw2, waw, full_hz;
  sb_entry_t             head, cmp_entry;
  sb_entry_t             entries [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid;
  logic [1:0]            fwd;
  word_t                 fwd_rs1, fwd_rs2;
  assign cmp_entry = '{rd: sb.cmp_rd, value: sb.cmp_value};
  sb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (sb.cmp_valid),
    .din     (cmp_entry),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head),
    .entries (entries),
    .valid   (valid)
  );
  // WAW blocking keeps each rd at most once in the queue, so the last hit is the only hit
  always_comb begin
    fwd     = '0;
    fwd_rs1 = '0;
    fwd_rs2 = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (FWD_EN && valid[k] && entries[k].rd == sb.iss_rs1) begin
        fwd[RS1] = 1'b1;
        fwd_rs1  = entries[k].value;
      end
      if (FWD_EN && valid[k] && sb.iss_use_rs2 && entries[k].rd == sb.iss_rs2) begin
        fwd[RS2] = 1'b1;
        fwd_rs2  = entries[k].value;
      end
    end
  end
  assign raw1     = pending[sb.iss_rs1] && !fwd[RS1];
  assign raw2     = sb.iss_use_rs2 && pending[sb.iss_rs2] && !fwd[RS2];
  assign waw      = sb.iss_long && pending[sb.iss_rd];
  assign full_hz  = sb.iss_long && outstanding == OW'(MAX_OUTSTANDING);
  assign stall    = reset && sb.iss_valid && (raw1 || raw2 || waw || full_hz);
  assign do_issue = sb.iss_valid && sb.iss_long && !stall && sb.iss_rd != '0;
  assign pop      = reset && !fifo_empty && !sb.s5_write_rd;
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      pending     <= (pending & ~(pop ? 32'd1 << head.rd : 32'd0)) | (do_issue ? 32'd1 << sb.iss_rd : 32'd0);
      outstanding <= outstanding + OW'(do_issue) - OW'(pop);
    end
  end
  assign sb.stall     = stall;
  assign sb.cmp_ready = !fifo_full;
  assign sb.wb_en     = pop;
  assign sb.wb_rd     = pop ? head.rd : '0;
  assign sb.wb_value  = pop ? head.value : '0;
  assign sb.fwd       = fwd;
  assign sb.fwd_rs1   = fwd_rs1;
  assign sb.fwd_rs2   = fwd_rs2;
`ifndef SYNTHESIS
  a_cmp_pending: assert property (@(posedge clock) disable iff (!reset)
    sb.cmp_valid && !fifo_full |-> pending[sb.cmp_rd]);
  a_cmp_rd_nonzero: assert property (@(posedge clock) disable iff (!reset)
    sb.cmp_valid |-> sb.cmp_rd != '0);
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
    pop && !do_issue |-> outstanding != '0);
`endif
endmodule

// File: tb/tb_long_op_scoreboard.sv
// tb_long_op_scoreboard: directed self-checking bench for long_op_scoreboard
module tb_long_op_scoreboard;
  import long_op_scoreboard_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  long_op_scoreboard_if sbif ();
  long_op_scoreboard #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(8)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sbif)
  );
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    sbif.iss_valid   = 1'b0;
    sbif.iss_long    = 1'b0;
    sbif.iss_rs1     = '0;
    sbif.iss_rs2     = '0;
    sbif.iss_use_rs2 = 1'b0;
    sbif.iss_rd      = '0;
    sbif.cmp_valid   = 1'b0;
    sbif.cmp_rd      = '0;
    sbif.cmp_value   = '0;
    sbif.s5_write_rd = 1'b0;
  endtask

  task automatic issue_long(input tag_t rd);
    sbif.iss_valid = 1'b1;
    sbif.iss_long  = 1'b1;
    sbif.iss_rd    = rd;
    sbif.iss_rs1   = '0;
    sbif.iss_use_rs2 = 1'b0;
    tick();
    sbif.iss_valid = 1'b0;
    sbif.iss_long  = 1'b0;
  endtask

  task automatic push(input tag_t rd, input word_t v);
    sbif.cmp_valid = 1'b1;
    sbif.cmp_rd    = rd;
    sbif.cmp_value = v;
    tick();
    sbif.cmp_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (sbif.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", sbif.stall); end
    tests++; if (sbif.cmp_ready !== 1'b1) begin fails++; $display("FAIL reset_cmp_ready: got %0b want 1", sbif.cmp_ready); end
    tests++; if (sbif.wb_en !== 1'b0) begin fails++; $display("FAIL reset_wb_en: got %0b want 0", sbif.wb_en); end
    tests++; if ({sbif.wb_rd, sbif.wb_value} !== 37'd0) begin fails++; $display("FAIL reset_wb_data: rd=%0d val=%h want 0", sbif.wb_rd, sbif.wb_value); end
    tests++; if (sbif.fwd !== 2'b00) begin fails++; $display("FAIL reset_fwd: got %b want 00", sbif.fwd); end
  endtask

  task automatic test_raw_stall();
    sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = 5'd5; #1;
    tests++; if (sbif.stall !== 1'b0) begin fails++; $display("FAIL raw_issue: stall=%0b want 0", sbif.stall); end
    tick();
    sbif.iss_long = 1'b0; sbif.iss_rd = '0; sbif.iss_rs1 = 5'd5;
    sbif.cmp_valid = 1'b1; sbif.cmp_rd = 5'd5; sbif.cmp_value = 32'h1234; #1;
    tests++; if (sbif.stall !== 1'b1) begin fails++; $display("FAIL raw_stall: stall=%0b want 1", sbif.stall); end
    tests++; if (sbif.wb_en !== 1'b0) begin fails++; $display("FAIL raw_no_same_cycle_wb: wb_en=%0b want 0", sbif.wb_en); end
    tick();
    sbif.cmp_valid = 1'b0; #1;
    tests++; if ({sbif.wb_en, sbif.wb_rd, sbif.wb_value} !== {1'b1, 5'd5, 32'h1234}) begin
      fails++; $display("FAIL raw_wb: en=%0b rd=%0d val=%h want 1/5/1234", sbif.wb_en, sbif.wb_rd, sbif.wb_value); end
`ifdef SB_FWD_EN
    tests++; if ({sbif.stall, sbif.fwd, sbif.fwd_rs1} !== {1'b0, 2'b01, 32'h1234}) begin
      fails++; $display("FAIL raw_fwd_rs1: stall=%0b fwd=%b v=%h want 0/01/1234", sbif.stall, sbif.fwd, sbif.fwd_rs1); end
`else
    tests++; if ({sbif.stall, sbif.fwd} !== {1'b1, 2'b00}) begin
      fails++; $display("FAIL raw_hold: stall=%0b fwd=%b want 1/00", sbif.stall, sbif.fwd); end
`endif
    tick();
    tests++; if ({sbif.stall, sbif.wb_en} !== 2'b00) begin
      fails++; $display("FAIL raw_release: stall=%0b wb_en=%0b want 0/0", sbif.stall, sbif.wb_en); end
    idle();
  endtask

  task automatic test_forward();
    issue_long(5'd7);
    sbif.s5_write_rd = 1'b1;
    push(5'd7, 32'hBEEF);
    sbif.iss_valid = 1'b1; sbif.iss_rs1 = 5'd2; sbif.iss_rs2 = 5'd7; sbif.iss_use_rs2 = 1'b1; #1;
    tests++; if (sbif.wb_en !== 1'b0) begin fails++; $display("FAIL fwd_s5_busy: wb_en=%0b want 0", sbif.wb_en); end
`ifdef SB_FWD_EN
    tests++; if ({sbif.fwd, sbif.fwd_rs2, sbif.stall} !== {2'b10, 32'hBEEF, 1'b0}) begin
      fails++; $display("FAIL fwd_rs2: fwd=%b v=%h stall=%0b want 10/beef/0", sbif.fwd, sbif.fwd_rs2, sbif.stall); end
`else
    tests++; if ({sbif.fwd, sbif.fwd_rs2, sbif.stall} !== {2'b00, 32'h0, 1'b1}) begin
      fails++; $display("FAIL fwd_disabled: fwd=%b v=%h stall=%0b want 00/0/1", sbif.fwd, sbif.fwd_rs2, sbif.stall); end
`endif
    sbif.iss_use_rs2 = 1'b0; #1;
    tests++; if ({sbif.fwd, sbif.stall} !== 3'b000) begin
      fails++; $display("FAIL fwd_no_use_rs2: fwd=%b stall=%0b want 00/0", sbif.fwd, sbif.stall); end
    sbif.iss_valid = 1'b0; sbif.s5_write_rd = 1'b0; #1;
    tests++; if ({sbif.wb_en, sbif.wb_rd, sbif.wb_value} !== {1'b1, 5'd7, 32'hBEEF}) begin
      fails++; $display("FAIL fwd_drain: en=%0b rd=%0d val=%h want 1/7/beef", sbif.wb_en, sbif.wb_rd, sbif.wb_value); end
    tick();
    idle();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) issue_long(tag_t'(10 + i));
    sbif.s5_write_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (sbif.cmp_ready !== 1'b1) begin fails++; $display("FAIL full_ready_%0d: got %0b want 1", i, sbif.cmp_ready); end
      push(tag_t'(10 + i), 32'hA0 + 32'(i));
    end
    tests++; if ({sbif.cmp_ready, sbif.wb_en} !== 2'b00) begin
      fails++; $display("FAIL full_block: ready=%0b wb_en=%0b want 0/0", sbif.cmp_ready, sbif.wb_en); end
    sbif.s5_write_rd = 1'b0; #1;
    tests++; if ({sbif.cmp_ready, sbif.wb_en} !== 2'b01) begin
      fails++; $display("FAIL full_pop_no_bypass: ready=%0b wb_en=%0b want 0/1", sbif.cmp_ready, sbif.wb_en); end
    for (int i = 0; i < 4; i++) begin
      tests++; if ({sbif.wb_en, sbif.wb_rd, sbif.wb_value} !== {1'b1, 5'(10 + i), 32'hA0 + 32'(i)}) begin
        fails++; $display("FAIL full_order_%0d: en=%0b rd=%0d val=%h want 1/%0d/%h", i, sbif.wb_en, sbif.wb_rd, sbif.wb_value, 10 + i, 32'hA0 + i); end
      tick();
    end
    tests++; if ({sbif.wb_en, sbif.cmp_ready} !== 2'b01) begin
      fails++; $display("FAIL full_empty: wb_en=%0b ready=%0b want 0/1", sbif.wb_en, sbif.cmp_ready); end
  endtask

  task automatic test_max_outstanding();
    int pulses = 0;
    for (int r = 1; r <= 8; r++) issue_long(tag_t'(r));
    sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = 5'd9; #1;
    tests++; if (sbif.stall !== 1'b1) begin fails++; $display("FAIL max_ninth_stall: stall=%0b want 1", sbif.stall); end
    push(5'd1, 32'h11);
    tests++; if ({sbif.wb_en, sbif.stall} !== 2'b11) begin
      fails++; $display("FAIL max_drain_cycle: wb_en=%0b stall=%0b want 1/1", sbif.wb_en, sbif.stall); end
    tick();
    tests++; if (sbif.stall !== 1'b0) begin fails++; $display("FAIL max_ninth_go: stall=%0b want 0", sbif.stall); end
    tick();
    sbif.iss_rd = 5'd10; #1;
    tests++; if (sbif.stall !== 1'b1) begin fails++; $display("FAIL max_refull: stall=%0b want 1", sbif.stall); end
    idle();
    for (int r = 2; r <= 9; r++) begin
      push(tag_t'(r), 32'(r));
      pulses += int'(sbif.wb_en);
    end
    tick();
    tests++; if (pulses != 8 || sbif.wb_en !== 1'b0) begin
      fails++; $display("FAIL max_cleanup: pulses=%0d wb_en=%0b want 8/0", pulses, sbif.wb_en); end
  endtask

  task automatic test_waw();
    issue_long(5'd3);
    sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = 5'd3; #1;
    tests++; if (sbif.stall !== 1'b1) begin fails++; $display("FAIL waw_stall: stall=%0b want 1", sbif.stall); end
    sbif.iss_long = 1'b0; sbif.iss_rd = 5'd0; #1;
    tests++; if (sbif.stall !== 1'b0) begin fails++; $display("FAIL waw_short_rd0: stall=%0b want 0", sbif.stall); end
    idle();
  endtask

  task automatic test_reset_mid_flight();
    issue_long(5'd20);
    issue_long(5'd21);
    sbif.s5_write_rd = 1'b1;
    push(5'd20, 32'h20);
    push(5'd21, 32'h21);
    tests++; if ({sbif.wb_en, dut.pending} !== {1'b0, 32'h0030_0008}) begin
      fails++; $display("FAIL mid_pre: wb_en=%0b pending=%h want 0/00300008", sbif.wb_en, dut.pending); end
    reset = 1'b0;
    sbif.s5_write_rd = 1'b0;
    tick();
    reset = 1'b1;
    sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = 5'd3; sbif.iss_rs1 = 5'd20; #1;
    tests++; if (dut.pending !== 32'h0) begin fails++; $display("FAIL mid_pending: got %h want 0", dut.pending); end
    tests++; if ({sbif.wb_en, sbif.cmp_ready, sbif.stall} !== 3'b010) begin
      fails++; $display("FAIL mid_outputs: wb_en=%0b ready=%0b stall=%0b want 0/1/0", sbif.wb_en, sbif.cmp_ready, sbif.stall); end
    idle();
    tick();
  endtask

  initial begin
    idle();
    repeat (2) tick();
    reset = 1'b1;
    #1;
    test_reset();
    test_raw_stall();
    test_forward();
    test_fifo_full();
    test_max_outstanding();
    test_waw();
    test_reset_mid_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
